// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter sharing one fixed-latency single-port memory
// Optional: define MEM_ARB_RR_EN for round-robin arbitration instead of fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_freeze,
  input  logic              d_rd_en,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_freeze,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             grant_d;
  logic             d_req;
  logic             any_req;
  logic             pick_d;

  assign d_req   = d_rd_en | d_wr_en;
  assign any_req = d_req | if_req;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // On contention the port that did not win last time is served.
  assign pick_d = d_req & (~if_req | ~last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_d <= pick_d;
    end
  end
`else
  // The data access belongs to the older instruction, so it always wins.
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      grant_d   <= 1'b0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_d   <= pick_d;
            mem_en    <= 1'b1;
            mem_we    <= pick_d & d_wr_en;
            mem_addr  <= pick_d ? {d_addr[ADDR_W-1:2], 2'b00} : {if_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= d_wdata;
            cnt       <= CNT_W'(WAIT_CYCLES - 1);
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (grant_d) begin
              d_ready <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign if_freeze  = if_req & ~if_ready;
  assign mem_freeze = d_req & ~d_ready;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between two requesters of the 5-stage core: the instruction-fetch stage (I port) and the memory stage (D port).
- Serialises accesses through a three-state FSM and returns per-port ready pulses.
- Drives per-port freeze outputs that stall the fetch stage and the EXE/MEM pipeline registers while their access is outstanding.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- WAIT_CYCLES, 4, cycles mem_en is held per access. Minimum 1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_ready  out  1  one-cycle completion pulse for the I port.
- if_rdata  out  DATA_W  fetched word; valid when if_ready=1.
- if_freeze  out  1  stall for the fetch stage.
- d_rd_en  in  1  data read request; held until d_ready.
- d_wr_en  in  1  data write request; held until d_ready.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle completion pulse for the D port.
- d_rdata  out  DATA_W  load data; valid when d_ready=1 after a read.
- mem_freeze  out  1  stall for the EXE/MEM pipeline.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; sampled at the end of the last access cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; counter=0; grant register=I.
  - All registered outputs to 0: if_ready, d_ready, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata.
  - Any in-flight access is aborted; mem_en drops immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request present: stay in IDLE.
  - Data request (d_rd_en|d_wr_en) and/or if_req present: grant one port (priority rule below).
  - On grant: latch address with bits[1:0] forced to 0, wdata, and we (=d_wr_en for D, 0 for I) into the mem_* registers; counter=WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - mem_en=1; mem_addr, mem_we, mem_wdata stable.
  - Counter decrements each cycle.
  - At the edge where counter==0: on reads, capture mem_rdata into the granted port's rdata register; clear mem_en and mem_we; go to DONE.
- DONE:
  - Granted port's ready=1 for exactly this cycle, then IDLE.
  - A pending request can be granted in the following IDLE cycle.
- Latency:
  - Request seen in cycle 0 → mem_en in cycles 1..WAIT_CYCLES → ready in cycle WAIT_CYCLES+1.
  - Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- Priority (default): D wins over I when both request in IDLE, because D belongs to the older instruction.
- Freeze (combinational):
  - if_freeze = if_req & ~if_ready.
  - mem_freeze = (d_rd_en|d_wr_en) & ~d_ready.
- Port values after grant:
  - Requester inputs are ignored after grant; the latched values are used.
  - A request withdrawn mid-access still completes.
- d_rd_en and d_wr_en both high: treated as a write.
- Writes do not modify d_rdata. if_rdata and d_rdata otherwise hold their last read value.
- Requesters drop req in the cycle after ready. A req still high in the following IDLE is a new request.
- Counter width: $clog2(WAIT_CYCLES+1).

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration.
  - A 1-bit last-grant register is updated on every grant and reset to I.
  - When both ports request in IDLE, the port not granted last wins.
  - A single requester is always granted.
- MEM_ARB_RR_EN undefined: fixed D-over-I priority; no last-grant register.

Test Plan:
- Fetch, WAIT_CYCLES=4, memory model returns addr^32'hA5A5_0000, if_req at cycle 0 with if_addr=32'h104 → mem_en=1 and mem_addr=32'h104 in cycles 1-4; if_ready=1 in cycle 5 with if_rdata=32'hA5A5_0104; if_freeze=1 in cycles 0-4.
- D write d_addr=32'h400 d_wdata=32'hDEAD_BEEF, then read 32'h400 → mem_we=1 in cycles 1-4; d_ready pulse in cycle 5; read completes with d_rdata=32'hDEAD_BEEF in cycle 11; d_rdata unchanged after the write.
- if_req and d_rd_en both asserted in cycle 0 (default build) → D served (d_ready cycle 5), I granted cycle 6 (if_ready cycle 11). Repeat with MEM_ARB_RR_EN and both held continuously → grants alternate D, I, D, I.
- Misaligned d_addr=32'h407 → mem_addr=32'h404.
- rst pulled low in cycle 2 of an access → mem_en, mem_we, ready and rdata go to 0 immediately; after release the FSM is in IDLE and a held request restarts from cycle 0 timing.
- WAIT_CYCLES=1, if_req held across back-to-back fetches → mem_en one cycle per access; if_ready pulses every 3 cycles.
